// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler: double-buffered 8x8 bicolour frame store with
// arbitrated back-buffer writes and a free-running row scan onto led.
module led_frame_scheduler #(
  parameter int SCAN_DIV  = 25002,
  parameter int BLANK_CYC = 64
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req0,
  input  logic [2:0]  row0,
  input  logic [15:0] data0,
  input  logic        req1,
  input  logic [2:0]  row1,
  input  logic [15:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  input  logic        clr,
  output logic        busy,
  input  logic        swap_req,
  output logic        swap_done,
  output logic [27:0] led
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DW_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DW_BLNK = DW'(BLANK_CYC);
  localparam logic [27:0] LED_RST = 28'h8FF_FFFF;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state, state_n;
  logic [2:0]    clr_row;
  logic [DW-1:0] dwell;
  logic [2:0]    row;
  logic          front;
  logic          pending;
  logic          last;
  logic [15:0]   mem [16];
  logic          g0, g1;
  logic          frame_end;
  logic          do_swap;
  logic [15:0]   cur;
  logic [15:0]   pat;
  logic [27:0]   led_n;

  // Arbitration and clear sequencing decisions for this edge.
  always_comb begin
    state_n = state;
    g0      = 1'b0;
    g1      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 && (!req1 || last)) begin
          g0 = 1'b1;
        end else if (req1) begin
          g1 = 1'b1;
        end
        if (clr) state_n = CLEAR;
      end
      CLEAR: begin
        if (clr_row == 3'd7) state_n = IDLE;
      end
    endcase
  end

  assign busy      = (state == CLEAR);
  assign frame_end = (dwell == DW_LAST) && (row == 3'd7);
  assign do_swap   = frame_end && pending && (state == IDLE) && !g0 && !g1;

  // FSM state and clear row walker.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      clr_row <= 3'd0;
    end else begin
      state   <= state_n;
      clr_row <= (state == CLEAR) ? clr_row + 3'd1 : 3'd0;
    end
  end

  // Registered grants and round-robin pointer.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      last <= 1'b1;
    end else begin
      gnt0 <= g0;
      gnt1 <= g1;
      if (g0) last <= 1'b0;
      else if (g1) last <= 1'b1;
    end
  end

  // Free-running row dwell counter and row index.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      dwell <= '0;
      row   <= 3'd0;
    end else if (dwell == DW_LAST) begin
      dwell <= '0;
      row   <= row + 3'd1;
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  // Swap request latch and front-bank flip at a frame boundary.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      front     <= 1'b0;
      pending   <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= do_swap;
      if (do_swap) begin
        front   <= ~front;
        pending <= 1'b0;
      end else if (swap_req) begin
        pending <= 1'b1;
      end
    end
  end

  // Back-bank writes from the granted requester or the clear walker.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (g0) mem[{~front, row0}] <= data0;
      else if (g1) mem[{~front, row1}] <= data1;
      if (state == CLEAR) mem[{~front, clr_row}] <= '0;
    end
  end

  // Active-low column pattern for the current front-bank row.
  always_comb begin
    cur = mem[{front, row}];
    pat = '1;
    for (int n = 0; n < 8; n++) begin
      pat[7-n]  = ~cur[8+n];
      pat[15-n] = ~cur[n];
    end
    if (dwell < DW_BLNK) pat = '1;
    led_n = {1'b1, row[0], row[1], row[2], 8'hFF, pat};
  end

  // Matrix drive register.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) led <= LED_RST;
    else led <= led_n;
  end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// tb_led_frame_scheduler: directed and random stimulus checked against
// a frame-level reference model of the LED frame scheduler.
module tb_led_frame_scheduler;

  localparam int SD = 4;
  localparam int BC = 1;
  localparam int FR = SD * 8;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0;
  logic [2:0]  row0 = '0;
  logic [15:0] data0 = '0;
  logic        req1 = 1'b0;
  logic [2:0]  row1 = '0;
  logic [15:0] data1 = '0;
  logic        gnt0, gnt1;
  logic        clr = 1'b0;
  logic        busy;
  logic        swap_req = 1'b0;
  logic        swap_done;
  logic [27:0] led;

  always #5 CLK = ~CLK;

  led_frame_scheduler #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .CLK(CLK), .reset(reset),
    .req0(req0), .row0(row0), .data0(data0),
    .req1(req1), .row1(row1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1),
    .clr(clr), .busy(busy),
    .swap_req(swap_req), .swap_done(swap_done),
    .led(led)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_bank [2][8];
  int          m_front, m_pend, m_clr_left, m_last, m_k;
  bit          m_g0, m_g1, m_sw;
  logic [27:0] m_led;

  task automatic chk(string tag, logic [27:0] got, logic [27:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] led_of(logic [15:0] px, int r, int d);
    logic [27:0] v;
    logic [2:0]  rr;
    v  = 28'hFFF_FFFF;
    rr = 3'(r);
    v[24] = rr[2];
    v[25] = rr[1];
    v[26] = rr[0];
    if (d >= BC) begin
      for (int c = 0; c < 8; c++) begin
        if (px[8+c]) v[7-c] = 1'b0;
        if (px[c]) v[15-c] = 1'b0;
      end
    end
    return v;
  endfunction

  task automatic m_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++) m_bank[b][r] = '0;
    m_front = 0;
    m_pend = 0;
    m_clr_left = 0;
    m_last = 1;
    m_k = 0;
    m_g0 = 0;
    m_g1 = 0;
    m_sw = 0;
  endtask

  task automatic chk_rst(string tag);
    chk({tag, "_led"}, led, 28'h8FF_FFFF);
    chk({tag, "_gnt0"}, 28'(gnt0), 28'd0);
    chk({tag, "_gnt1"}, 28'(gnt1), 28'd0);
    chk({tag, "_swap"}, 28'(swap_done), 28'd0);
    chk({tag, "_busy"}, 28'(busy), 28'd0);
  endtask

  task automatic step();
    int r;
    int d;
    bit idle;
    r = (m_k / SD) % 8;
    d = m_k % SD;
    idle = (m_clr_left == 0);
    m_led = led_of(m_bank[m_front][r], r, d);
    m_g0 = idle && req0 && (!req1 || m_last == 1);
    m_g1 = idle && req1 && !m_g0;
    m_sw = (d == SD - 1) && (r == 7) && (m_pend != 0) && idle
           && !m_g0 && !m_g1;
    if (m_g0) begin
      m_bank[1-m_front][row0] = data0;
      m_last = 0;
    end
    if (m_g1) begin
      m_bank[1-m_front][row1] = data1;
      m_last = 1;
    end
    if (!idle) begin
      m_bank[1-m_front][8-m_clr_left] = '0;
      m_clr_left--;
    end else if (clr) begin
      m_clr_left = 8;
    end
    if (m_sw) begin
      m_front = 1 - m_front;
      m_pend = 0;
    end else if (swap_req) begin
      m_pend = 1;
    end
    m_k++;
    @(posedge CLK);
    #1;
    chk("led", led, m_led);
    chk("gnt0", 28'(gnt0), 28'(m_g0));
    chk("gnt1", 28'(gnt1), 28'(m_g1));
    chk("swap_done", 28'(swap_done), 28'(m_sw));
    chk("busy", 28'(busy), 28'(m_clr_left != 0));
  endtask

  task automatic run_to_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    for (int i = 0; i < 3 * FR && !m_sw; i++) step();
    chk("swap_seen", 28'(swap_done), 28'd1);
  endtask

  initial begin
    int nb;
    int ns;
    m_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk_rst("reset");
    reset = 1'b1;

    // idle scan
    repeat (40) step();

    // single write then swap
    req0 = 1'b1;
    row0 = 3'd3;
    data0 = 16'h8001;
    step();
    req0 = 1'b0;
    run_to_swap();
    for (int i = 0; i < 2 * FR && (m_k % FR) != 12; i++) step();
    step();
    chk("row3_blank", led, 28'hEFF_FFFF);
    step();
    step();
    chk("row3_lit", led, 28'hEFF_7FFE);
    repeat (20) step();

    // contention
    req0 = 1'b1;
    row0 = 3'd1;
    data0 = 16'($urandom);
    req1 = 1'b1;
    row1 = 3'd5;
    data1 = 16'($urandom);
    repeat (4) step();
    req0 = 1'b0;
    req1 = 1'b0;
    run_to_swap();
    repeat (FR) step();

    // fill, clear with a pending write
    for (int r = 0; r < 8; r++) begin
      req0 = 1'b1;
      row0 = 3'(r);
      data0 = 16'hFFFF;
      step();
    end
    req0 = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    nb = busy ? 1 : 0;
    req1 = 1'b1;
    row1 = 3'($urandom_range(0, 7));
    data1 = 16'($urandom);
    for (int i = 0; i < 30 && req1; i++) begin
      step();
      if (busy) nb++;
      if (m_g1) req1 = 1'b0;
    end
    req1 = 1'b0;
    chk("busy_len", 28'(nb), 28'd8);
    run_to_swap();
    repeat (FR) step();

    // swap requested while a clear spans the boundary
    for (int i = 0; i < 2 * FR && (m_k % FR) != 26; i++) step();
    clr = 1'b1;
    swap_req = 1'b1;
    step();
    clr = 1'b0;
    swap_req = 1'b0;
    ns = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (swap_done) ns++;
    end
    chk("swap_in_clear", 28'(ns), 28'd0);
    ns = 0;
    for (int i = 0; i < FR; i++) begin
      step();
      if (swap_done) ns++;
    end
    chk("swap_deferred", 28'(ns), 28'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (!req0 || m_g0) begin
        req0 = ($urandom_range(0, 2) != 0);
        row0 = 3'($urandom);
        data0 = 16'($urandom);
      end
      if (!req1 || m_g1) begin
        req1 = ($urandom_range(0, 2) != 0);
        row1 = 3'($urandom);
        data1 = 16'($urandom);
      end
      clr = ($urandom_range(0, 40) == 0);
      swap_req = ($urandom_range(0, 20) == 0);
      step();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    clr = 1'b0;
    swap_req = 1'b0;
    repeat (10) step();

    // async reset during clear with a swap pending
    clr = 1'b1;
    step();
    clr = 1'b0;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    step();
    chk("pre_rst_busy", 28'(busy), 28'd1);
    reset = 1'b0;
    #2;
    chk_rst("async_rst");
    @(posedge CLK);
    #1;
    chk_rst("held_rst");
    reset = 1'b1;
    m_reset();
    repeat (3 * FR) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
